// File: rtl/shift_cmd_rx_pkg.sv
// Shared types and constants for the serial shift-command receiver.
package shift_cmd_rx_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned CMD_BITS   = 2;
    localparam int unsigned FRAME_BITS = DATA_BITS + CMD_BITS;

    localparam logic [CMD_BITS-1:0] CMD_SHL = 2'b00;
    localparam logic [CMD_BITS-1:0] CMD_SHR = 2'b01;
    localparam logic [CMD_BITS-1:0] CMD_ROL = 2'b10;
    localparam logic [CMD_BITS-1:0] CMD_ROR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } state_t;

    // Payload as it sits in the shift buffer: first-received bit at bit 0.
    typedef struct packed {
        logic [CMD_BITS-1:0]  cmd;
        logic [DATA_BITS-1:0] data;
    } frame_t;

endpackage

// File: rtl/shift_cmd_rx_sync.sv
// Multi-flop synchronizer for the async serial line; resets to the idle (high) level.
module rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_a,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst_a) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/shift_cmd_rx.sv
// UART-style frame receiver delivering a data byte and a 2-bit shift/rotate
// command to the universal shift register, with load / frame_err strobes.
module shift_cmd_rx
    import shift_cmd_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                rst_a,
    input  logic                rx_in,
    output logic [DATA_BITS-1:0] ip,
    output logic [CMD_BITS-1:0]  sh_ro_lt_rt,
    output logic                load,
    output logic                frame_err,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);

    logic                  rxs;
    logic                  rxs_prev_q;
    state_t                state_q;
    logic [CNT_W-1:0]      baud_q;
    logic [BIT_W-1:0]      bit_q;
    logic [FRAME_BITS-1:0] buf_q;
    frame_t                frame;
    logic [DATA_BITS-1:0]  ip_q;
    logic [CMD_BITS-1:0]   cmd_q;
    logic                  load_q;
    logic                  fe_q;
    logic                  busy_q;

    rx_sync #(
        .STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .clk  (clk),
        .rst_a(rst_a),
        .d_i  (rx_in),
        .q_o  (rxs)
    );

    assign frame = frame_t'(buf_q);

    // Receive FSM: baud counter restarts on every sample so samples stay at mid-bit.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q    <= IDLE;
            rxs_prev_q <= 1'b1;
            baud_q     <= '0;
            bit_q      <= '0;
            buf_q      <= '0;
            ip_q       <= '0;
            cmd_q      <= '0;
            load_q     <= 1'b0;
            fe_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            load_q     <= 1'b0;
            fe_q       <= 1'b0;
            rxs_prev_q <= rxs;
            case (state_q)
                IDLE: begin
                    if (rxs_prev_q && !rxs) begin
                        state_q <= START;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_q == HALF_LAST) begin
                        baud_q <= '0;
                        if (!rxs) begin
                            state_q <= DATA;
                            bit_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_q == FULL_LAST) begin
                        baud_q <= '0;
                        buf_q  <= {rxs, buf_q[FRAME_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_q == FULL_LAST) begin
                        baud_q <= '0;
                        if (rxs) begin
                            ip_q    <= frame.data;
                            cmd_q   <= frame.cmd;
                            load_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            fe_q    <= 1'b1;
                            state_q <= WAIT_HI;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                WAIT_HI: begin
                    if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ip          = ip_q;
    assign sh_ro_lt_rt = cmd_q;
    assign load        = load_q;
    assign frame_err   = fe_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_shift_cmd_rx.sv
// Directed + randomized bench for shift_cmd_rx; a frame-level model predicts strobes and outputs.
module tb_shift_cmd_rx;

    localparam int CPB       = 16;
    localparam int SYNC      = 2;
    localparam int LATENCY   = SYNC + CPB / 2 + 11 * CPB + 1;
    localparam int FRAME_CYC = 12 * CPB;

    typedef struct {
        int         cyc;
        logic [7:0] ip;
        logic [1:0] cmd;
        logic       busy;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] cmd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rx_in;
    logic [7:0] ip;
    logic [1:0] sh_ro_lt_rt;
    logic       load;
    logic       frame_err;
    logic       busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   fe_cnt = 0;
    int   both_cnt = 0;
    int   fall_cyc = 0;
    ev_t  evq[$];
    exp_t expq[$];

    shift_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .rx_in      (rx_in),
        .ip         (ip),
        .sh_ro_lt_rt(sh_ro_lt_rt),
        .load       (load),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (load === 1'b1) evq.push_back('{cyc, ip, sh_ro_lt_rt, busy});
        if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
        if (load === 1'b1 && frame_err === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Frame on the wire: start, 8 data LSB first, cmd[0], cmd[1], stop.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] c, input logic stop);
        logic [11:0] bits;
        bits     = {stop, c, d, 1'b0};
        fall_cyc = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            rx_in = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    initial begin
        int   base;
        int   fe0;
        int   nbusy;
        int   gap;
        logic [7:0] rd;
        logic [1:0] rc;
        logic       rstop;
        logic [7:0] last_ip;
        logic [1:0] last_cmd;
        logic [11:0] bits55;

        rx_in = 1'b1;
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        chk("rst_ip", 32'(ip), 32'h00);
        chk("rst_cmd", 32'(sh_ro_lt_rt), 32'h0);
        chk("rst_load", 32'(load), 32'h0);
        chk("rst_fe", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Good frame
        base = evq.size();
        fe0  = fe_cnt;
        send_frame(8'hA5, 2'b10, 1'b1);
        idle(20);
        chk("good_nload", 32'(evq.size() - base), 32'd1);
        if (evq.size() > base) begin
            chk("good_ip", 32'(evq[base].ip), 32'hA5);
            chk("good_cmd", 32'(evq[base].cmd), 32'h2);
            chk("good_busy_at_load", 32'(evq[base].busy), 32'h0);
            chk_rng("good_latency", evq[base].cyc - fall_cyc, LATENCY - 1, LATENCY + 1);
        end
        chk("good_no_fe", 32'(fe_cnt - fe0), 32'd0);

        // Start-bit glitch
        base  = evq.size();
        fe0   = fe_cnt;
        nbusy = 0;
        rx_in = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nbusy++;
            if (i == 3) rx_in = 1'b1;
        end
        chk_rng("glitch_busy_len", nbusy, 6, 12);
        chk("glitch_busy_end", 32'(busy), 32'h0);
        chk("glitch_no_load", 32'(evq.size() - base), 32'd0);
        chk("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);

        // Framing error followed by a held-low line
        base = evq.size();
        fe0  = fe_cnt;
        send_frame(8'h3C, 2'b01, 1'b0);
        rx_in = 1'b0;
        repeat (40) @(negedge clk);
        chk("fe_busy_held", 32'(busy), 32'h1);
        idle(10);
        chk("fe_one_pulse", 32'(fe_cnt - fe0), 32'd1);
        chk("fe_no_load", 32'(evq.size() - base), 32'd0);
        chk("fe_ip_kept", 32'(ip), 32'hA5);
        chk("fe_cmd_kept", 32'(sh_ro_lt_rt), 32'h2);
        chk("fe_busy_end", 32'(busy), 32'h0);

        // Back-to-back frames with no idle gap
        base = evq.size();
        send_frame(8'hFF, 2'b11, 1'b1);
        send_frame(8'h01, 2'b00, 1'b1);
        idle(20);
        chk("b2b_nload", 32'(evq.size() - base), 32'd2);
        if (evq.size() >= base + 2) begin
            chk("b2b_ip0", 32'(evq[base].ip), 32'hFF);
            chk("b2b_cmd0", 32'(evq[base].cmd), 32'h3);
            chk("b2b_ip1", 32'(evq[base+1].ip), 32'h01);
            chk("b2b_cmd1", 32'(evq[base+1].cmd), 32'h0);
            chk("b2b_spacing", 32'(evq[base+1].cyc - evq[base].cyc), 32'(FRAME_CYC));
        end

        // Reset during data bit 4 of 0x55
        base   = evq.size();
        bits55 = {1'b1, 2'b00, 8'h55, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_in = bits55[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = bits55[5];
        repeat (CPB / 2) @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        idle(2 * CPB);
        chk("rstmid_no_load", 32'(evq.size() - base), 32'd0);
        chk("rstmid_ip_clr", 32'(ip), 32'h00);
        chk("rstmid_busy", 32'(busy), 32'h0);
        send_frame(8'h81, 2'b01, 1'b1);
        idle(10);
        chk("rstmid_nload", 32'(evq.size() - base), 32'd1);
        chk("rstmid_ip", 32'(ip), 32'h81);
        chk("rstmid_cmd", 32'(sh_ro_lt_rt), 32'h1);

        // Randomized frames against the frame-level model
        base     = evq.size();
        fe0      = fe_cnt;
        last_ip  = 8'h81;
        last_cmd = 2'b01;
        expq.delete();
        gap = 0;
        for (int n = 0; n < 20; n++) begin
            rd    = 8'($urandom);
            rc    = 2'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            send_frame(rd, rc, rstop);
            if (rstop) begin
                expq.push_back('{rd, rc});
                last_ip  = rd;
                last_cmd = rc;
                gap = $urandom_range(0, 2 * CPB);
            end else begin
                rx_in = 1'b0;
                repeat ($urandom_range(0, 30)) @(negedge clk);
                gap = $urandom_range(CPB, 3 * CPB);
            end
            if (gap > 0) idle(gap);
        end
        idle(2 * CPB);
        chk("rand_nload", 32'(evq.size() - base), 32'(expq.size()));
        chk("rand_nfe", 32'(fe_cnt - fe0), 32'(20 - expq.size()));
        for (int i = 0; i < expq.size() && base + i < evq.size(); i++) begin
            chk($sformatf("rand_ip%0d", i), 32'(evq[base+i].ip), 32'(expq[i].data));
            chk($sformatf("rand_cmd%0d", i), 32'(evq[base+i].cmd), 32'(expq[i].cmd));
        end
        chk("rand_final_ip", 32'(ip), 32'(last_ip));
        chk("rand_final_cmd", 32'(sh_ro_lt_rt), 32'(last_cmd));
        chk("never_load_and_fe", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
